// File: rtl/embed_onchip_ram_pipelined.sv
// Avalon-MM single-port on-chip RAM slave with pipelined reads and a hardware clear engine.
// Latency: READ_LATENCY (1 or 2) unstalled cycles from accepted read to readdatavalid; writes land at the accepting edge.
// Backpressure: waitrequest while the clear engine runs or while stalled (clken=0 or reset_req=1); a stall freezes array and pipeline.
module embed_onchip_ram_pipelined #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 12,
    parameter int                DEPTH          = 4096,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic                  clear_req,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    // One extra counter bit so DEPTH == 2**ADDR_W is representable without wrap.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               stall;
    logic               accept;
    logic               addr_ok;
    logic               wr_bus;
    logic               rd_issue;

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [BE_W-1:0]    mem_be;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  ram_q;

    logic               s1_vld_q;
    logic               s1_zero_q;
    logic [DATA_W-1:0]  s1_data;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign stall       = ~clken | reset_req;
    assign busy        = (state_q == ST_CLEAR);
    assign waitrequest = busy | stall;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign addr_ok     = ({1'b0, address} < DEPTH_C);
    // Out-of-range writes are silently dropped.
    assign wr_bus      = accept & write & addr_ok;
    // A combined read+write performs the write only.
    assign rd_issue    = accept & read & ~write;

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                ST_READY: begin
                    if (clear_req) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    // clear_req is deliberately ignored here: a pass never restarts.
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port mux: the clear engine owns the port while busy, and the
    // bus cannot be accepted then, so there is never a conflict.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = writedata;
        mem_be    = byteenable;
        if (!stall) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = INIT_VALUE;
                mem_be    = '1;
            end else if (wr_bus) begin
                mem_we = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Block RAM: byte-enabled write, synchronous read. The read port only
    // loads on an accepted read, so a result stays put through stalls and
    // is unaffected by clear writes that follow it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
        if (rd_issue && addr_ok) begin
            ram_q <= mem[address];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline stage 1. s1_zero_q forces the output to zero for
    // out-of-range reads and for the post-reset state (the RAM output
    // register itself has no reset).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q  <= 1'b0;
            s1_zero_q <= 1'b1;
        end else if (!stall) begin
            s1_vld_q <= rd_issue;
            if (rd_issue) begin
                s1_zero_q <= ~addr_ok;
            end
        end
    end

    assign s1_data = s1_zero_q ? '0 : ram_q;

    // ------------------------------------------------------------------
    // Output: direct from stage 1, or through one extra register.
    // The strobe is masked while stalled; the pending result is held and
    // shown again in the first unstalled cycle.
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              s2_vld_q;
            logic [DATA_W-1:0] s2_data_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s2_vld_q  <= 1'b0;
                    s2_data_q <= '0;
                end else if (!stall) begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_data_q <= s1_data;
                    end
                end
            end

            assign readdata      = s2_data_q;
            assign readdatavalid = s2_vld_q & ~stall;
        end else begin : g_lat1
            assign readdata      = s1_data;
            assign readdatavalid = s1_vld_q & ~stall;
        end
    endgenerate

endmodule
